// File: rtl/ext_arbiter.sv
// ---------------------------------------------------------------------------
// ext_arbiter
//
// Shares one combinational immediate Extender between two requesters:
// requester 0 (decode stage) and requester 1 (branch-target unit). In the
// grant cycle the winner's mode/immediate are steered onto ext_mode /
// ext_imm16. The Extender's result (ext_imm32) is captured at the end of
// that cycle, together with the winner's id and a one-cycle acknowledge.
//
// Configuration macro:
//   EXT_ARB_RR_EN  defined   -> round robin on contention (the requester
//                               other than last_id wins)
//                  undefined -> requester 0 always wins on contention;
//                               last_id is still tracked
//
// Ports:
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous active-high reset
//   req0/req1  in   1   request from requester 0 / 1
//   mode0/1    in   2   extender mode (01 zero-high, 10 sign, 11 zero-low,
//                       00 yields zero)
//   imm0/1     in   16  immediate to extend
//   stall      in   1   pipeline freeze, no grant while high
//   ext_mode   out  2   mode to the shared Extender (00 when no grant)
//   ext_imm16  out  16  immediate to the shared Extender (0 when no grant)
//   ext_imm32  in   32  combinational result from the shared Extender
//   ack0/ack1  out  1   registered one-cycle acknowledge to the winner
//   imm32_o    out  32  registered extended result
//   valid_o    out  1   imm32_o/id_o valid this cycle
//   id_o       out  1   requester index owning imm32_o
// ---------------------------------------------------------------------------
module ext_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  mode0,
  input  logic [1:0]  mode1,
  input  logic [15:0] imm0,
  input  logic [15:0] imm1,
  input  logic        stall,
  output logic [1:0]  ext_mode,
  output logic [15:0] ext_imm16,
  input  logic [31:0] ext_imm32,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] imm32_o,
  output logic        valid_o,
  output logic        id_o
);

  typedef enum logic {
    SRC_DEC = 1'b0,
    SRC_BTU = 1'b1
  } src_e;

`ifdef EXT_ARB_RR_EN
  localparam bit FIXED_PRIO = 1'b0;
`else
  localparam bit FIXED_PRIO = 1'b1;
`endif

  src_e last_id;
  src_e winner;
  src_e rr_pick;
  logic elig0;
  logic elig1;
  logic grant;

  always_comb begin
    // A requester acked this cycle is masked, so a held request is seen as
    // a new one only from the following cycle.
    elig0 = req0 & ~ack0;
    elig1 = req1 & ~ack1;
    grant = ~reset & ~stall & (elig0 | elig1);

    rr_pick = (last_id == SRC_DEC) ? SRC_BTU : SRC_DEC;

    winner = SRC_DEC;
    if (elig0 && elig1) begin
      winner = FIXED_PRIO ? SRC_DEC : rr_pick;
    end else if (elig1) begin
      winner = SRC_BTU;
    end

    // grant is already low during reset, so the Extender inputs idle at zero.
    ext_mode  = '0;
    ext_imm16 = '0;
    if (grant) begin
      case (winner)
        SRC_DEC: begin
          ext_mode  = mode0;
          ext_imm16 = imm0;
        end
        SRC_BTU: begin
          ext_mode  = mode1;
          ext_imm16 = imm1;
        end
        default: begin
          ext_mode  = '0;
          ext_imm16 = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      valid_o <= 1'b0;
      imm32_o <= '0;
      id_o    <= 1'b0;
      last_id <= SRC_BTU;
    end else if (grant) begin
      ack0    <= (winner == SRC_DEC);
      ack1    <= (winner == SRC_BTU);
      valid_o <= 1'b1;
      imm32_o <= ext_imm32;
      id_o    <= winner;
      last_id <= winner;
    end else begin
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      valid_o <= 1'b0;
    end
  end

endmodule
